// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline run controller: widths, FSM states and
// the host command bytes also decoded by the UART command path.
package pipeline_ctrl_pkg;

  localparam int unsigned NB_DATA = 32;
  localparam int unsigned N_BITS  = 8;
  localparam int unsigned STATE_W = 3;

  localparam logic [N_BITS-1:0] CMD_RUN    = 8'h63;
  localparam logic [N_BITS-1:0] CMD_STEP   = 8'h73;
  localparam logic [N_BITS-1:0] CMD_RELOAD = 8'h72;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_READY     = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP      = 3'd3,
    ST_DUMP      = 3'd4,
    ST_WAIT_DUMP = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/pipeline_run_controller_if.sv
// Control/status bundle between the UART/debug side and the run controller.
interface pipeline_run_controller_if;
  import pipeline_ctrl_pkg::*;

  logic                 load_done_i;
  logic                 cmd_valid_i;
  logic [N_BITS-1:0]    cmd_i;
  logic                 halt_wb_i;
  logic [NB_DATA-1:0]   max_cycles_i;
  logic                 dump_done_i;
  logic                 en_pipeline_o;
  logic                 dump_start_o;
  logic                 en_read_mem_o;
  logic [NB_DATA-1:0]   cycle_count_o;
  logic                 timeout_o;
  logic [STATE_W-1:0]   state_o;

  modport slave (
    input  load_done_i, cmd_valid_i, cmd_i, halt_wb_i, max_cycles_i, dump_done_i,
    output en_pipeline_o, dump_start_o, en_read_mem_o, cycle_count_o, timeout_o, state_o
  );

  modport master (
    output load_done_i, cmd_valid_i, cmd_i, halt_wb_i, max_cycles_i, dump_done_i,
    input  en_pipeline_o, dump_start_o, en_read_mem_o, cycle_count_o, timeout_o, state_o
  );

endinterface

// File: rtl/run_cycle_counter.sv
// Saturating enabled-cycle counter with the watchdog compare on its next value.
module run_cycle_counter
  import pipeline_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  input  logic [NB_DATA-1:0] max_cycles,
  output logic [NB_DATA-1:0] count,
  output logic               hit_c
);

  logic [NB_DATA-1:0] count_q;
  logic [NB_DATA-1:0] count_next;

  // Hold at all-ones rather than wrapping back to zero.
  always_comb begin
    count_next = (count_q == '1) ? count_q : count_q + NB_DATA'(1);
    hit_c      = (max_cycles != '0) && (count_next == max_cycles);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_next;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_run_controller.sv
// Gates the MIPS pipeline enable for continuous run / single step and hands
// off to the debug sender when a HALT retires or the watchdog expires.
module pipeline_run_controller
  import pipeline_ctrl_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  pipeline_run_controller_if.slave   bus
);

  state_t state, next_state;

  logic en_pipeline_q, en_pipeline_d;
  logic dump_start_q,  dump_start_d;
  logic en_read_mem_q, en_read_mem_d;
  logic timeout_q,     timeout_d;
  logic cnt_clear, cnt_inc, cnt_hit_c;
  logic [NB_DATA-1:0] cnt_value;

  run_cycle_counter u_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear),
    .inc        (cnt_inc),
    .max_cycles (bus.max_cycles_i),
    .count      (cnt_value),
    .hit_c      (cnt_hit_c)
  );

  // Next state; registered outputs are decoded from it so they track the state.
  always_comb begin
    next_state = state;
    timeout_d  = timeout_q;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.load_done_i) begin
          next_state = ST_READY;
          cnt_clear  = 1'b1;
          timeout_d  = 1'b0;
        end
      end
      ST_READY: begin
        if (bus.cmd_valid_i) begin
          if (bus.cmd_i == CMD_RUN) begin
            next_state = ST_RUN;
          end else if (bus.cmd_i == CMD_STEP) begin
            next_state = ST_STEP;
          end
        end
      end
      ST_RUN: begin
        cnt_inc = 1'b1;
        // Halt wins over a same-cycle watchdog hit.
        if (bus.halt_wb_i) begin
          next_state = ST_DUMP;
        end else if (cnt_hit_c) begin
          next_state = ST_DUMP;
          timeout_d  = 1'b1;
        end
      end
      ST_STEP: begin
        cnt_inc    = 1'b1;
        next_state = ST_DUMP;
      end
      ST_DUMP: begin
        next_state = ST_WAIT_DUMP;
      end
      ST_WAIT_DUMP: begin
        if (bus.dump_done_i) begin
          next_state = (bus.halt_wb_i || timeout_q) ? ST_DONE : ST_READY;
        end
      end
      ST_DONE: begin
        if (bus.cmd_valid_i && (bus.cmd_i == CMD_RELOAD)) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    en_pipeline_d = (next_state == ST_RUN) || (next_state == ST_STEP);
    dump_start_d  = (next_state == ST_DUMP);
    en_read_mem_d = (next_state != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      en_pipeline_q <= 1'b0;
      dump_start_q  <= 1'b0;
      en_read_mem_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state         <= next_state;
      en_pipeline_q <= en_pipeline_d;
      dump_start_q  <= dump_start_d;
      en_read_mem_q <= en_read_mem_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.en_pipeline_o = en_pipeline_q;
  assign bus.dump_start_o  = dump_start_q;
  assign bus.en_read_mem_o = en_read_mem_q;
  assign bus.timeout_o     = timeout_q;
  assign bus.cycle_count_o = cnt_value;
  assign bus.state_o       = STATE_W'(state);

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Bench for pipeline_run_controller: directed scenarios plus randomized
// load/step/run sequences checked against an arithmetic run-length model.
module tb_pipeline_run_controller;
  import pipeline_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pipeline_run_controller_if bus ();

  pipeline_run_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks  = 0;
  int n_fail    = 0;
  int en_seen   = 0;
  int dump_seen = 0;
  int c_model   = 0;

  localparam logic [63:0] S_IDLE  = 64'd0;
  localparam logic [63:0] S_READY = 64'd1;
  localparam logic [63:0] S_RUN   = 64'd2;
  localparam logic [63:0] S_STEP  = 64'd3;
  localparam logic [63:0] S_DUMP  = 64'd4;
  localparam logic [63:0] S_WAIT  = 64'd5;
  localparam logic [63:0] S_DONE  = 64'd6;

  always @(negedge clock) begin
    if (bus.en_pipeline_o) en_seen++;
    if (bus.dump_start_o)  dump_seen++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_i       = c;
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic do_load(input bit with_cmd);
    bus.load_done_i = 1'b1;
    if (with_cmd) begin
      bus.cmd_valid_i = 1'b1;
      bus.cmd_i       = CMD_RUN;
    end
    tick();
    bus.load_done_i = 1'b0;
    bus.cmd_valid_i = 1'b0;
    c_model = 0;
    check("load_state", 64'(bus.state_o), S_READY);
    check("load_count", 64'(bus.cycle_count_o), 64'd0);
    check("load_timeout", 64'(bus.timeout_o), 64'd0);
    check("load_en", 64'(bus.en_pipeline_o), 64'd0);
    check("load_rdmem", 64'(bus.en_read_mem_o), 64'd1);
  endtask

  // Entered with the controller in DUMP; completes the dump handshake.
  task automatic finish_dump(input logic [63:0] exp_state);
    check("dump_start", 64'(bus.dump_start_o), 64'd1);
    tick();
    check("wait_state", 64'(bus.state_o), S_WAIT);
    check("wait_no_en", 64'(bus.en_pipeline_o), 64'd0);
    repeat ($urandom_range(0, 3)) tick();
    bus.dump_done_i = 1'b1;
    tick();
    bus.dump_done_i = 1'b0;
    check("after_dump_state", 64'(bus.state_o), exp_state);
  endtask

  task automatic step_case(input bit halt_at_wb);
    int e0, d0;
    e0 = en_seen;
    d0 = dump_seen;
    bus.halt_wb_i = halt_at_wb;
    send_cmd(CMD_STEP);
    check("step_state", 64'(bus.state_o), S_STEP);
    check("step_en", 64'(bus.en_pipeline_o), 64'd1);
    c_model++;
    tick();
    check("step_to_dump", 64'(bus.state_o), S_DUMP);
    finish_dump(halt_at_wb ? S_DONE : S_READY);
    check("step_count", 64'(bus.cycle_count_o), 64'(c_model));
    check("step_en_cycles", 64'(en_seen - e0), 64'd1);
    check("step_dumps", 64'(dump_seen - d0), 64'd1);
  endtask

  // Halt is seen in the h-th RUN cycle; watchdog limit m counts from load.
  task automatic run_case(input int m, input int h);
    int e0, d0, wd_len, run_len;
    bit exp_to;
    logic [7:0] junk [4];
    junk[0] = CMD_STEP; junk[1] = 8'h78; junk[2] = CMD_RELOAD; junk[3] = CMD_RUN;
    e0 = en_seen;
    d0 = dump_seen;
    wd_len  = (m != 0 && m > c_model) ? (m - c_model) : 1000;
    run_len = (h < wd_len) ? h : wd_len;
    exp_to  = (wd_len < h);
    bus.max_cycles_i = 32'(m);
    bus.halt_wb_i    = 1'b0;
    send_cmd(CMD_RUN);
    check("run_state", 64'(bus.state_o), S_RUN);
    for (int i = 1; i <= 64; i++) begin
      if (bus.state_o != 3'd2) break;
      bus.halt_wb_i   = (i >= h);
      bus.cmd_valid_i = ($urandom_range(0, 3) == 0);
      bus.cmd_i       = junk[$urandom_range(0, 3)];
      tick();
    end
    bus.cmd_valid_i = 1'b0;
    c_model += run_len;
    check("run_to_dump", 64'(bus.state_o), S_DUMP);
    check("run_timeout", 64'(bus.timeout_o), 64'(exp_to));
    finish_dump(S_DONE);
    check("run_count", 64'(bus.cycle_count_o), 64'(c_model));
    check("run_en_cycles", 64'(en_seen - e0), 64'(run_len));
    check("run_dumps", 64'(dump_seen - d0), 64'd1);
    check("done_timeout", 64'(bus.timeout_o), 64'(exp_to));
    send_cmd(CMD_RUN);
    check("done_ignores_c", 64'(bus.state_o), S_DONE);
    send_cmd(CMD_STEP);
    check("done_ignores_s", 64'(bus.state_o), S_DONE);
    bus.halt_wb_i = 1'b0;
    send_cmd(CMD_RELOAD);
    check("reload_state", 64'(bus.state_o), S_IDLE);
    check("reload_rdmem", 64'(bus.en_read_mem_o), 64'd0);
    check("reload_en", 64'(bus.en_pipeline_o), 64'd0);
  endtask

  task automatic reset_mid_run();
    int d0;
    do_load(1'b0);
    bus.max_cycles_i = 32'd0;
    bus.halt_wb_i    = 1'b0;
    send_cmd(CMD_RUN);
    repeat (4) tick();
    check("mid_run_en", 64'(bus.en_pipeline_o), 64'd1);
    d0 = dump_seen;
    #2;
    reset = 1'b0;
    #1;
    check("rst_en", 64'(bus.en_pipeline_o), 64'd0);
    check("rst_state", 64'(bus.state_o), S_IDLE);
    check("rst_count", 64'(bus.cycle_count_o), 64'd0);
    check("rst_rdmem", 64'(bus.en_read_mem_o), 64'd0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("rst_stays_idle", 64'(bus.state_o), S_IDLE);
    check("rst_no_dump", 64'(dump_seen - d0), 64'd0);
    c_model = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nsteps, m, h;
    bus.load_done_i  = 1'b0;
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_i        = 8'h00;
    bus.halt_wb_i    = 1'b0;
    bus.max_cycles_i = 32'd0;
    bus.dump_done_i  = 1'b0;
    #12;
    check("reset_state", 64'(bus.state_o), S_IDLE);
    check("reset_en", 64'(bus.en_pipeline_o), 64'd0);
    check("reset_dump", 64'(bus.dump_start_o), 64'd0);
    check("reset_rdmem", 64'(bus.en_read_mem_o), 64'd0);
    check("reset_count", 64'(bus.cycle_count_o), 64'd0);
    check("reset_timeout", 64'(bus.timeout_o), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Commands in IDLE are ignored.
    send_cmd(CMD_RUN);
    check("idle_ignores_c", 64'(bus.state_o), S_IDLE);

    // Halt after 10 enable cycles: 11 enabled cycles including the halt cycle.
    do_load(1'b0);
    run_case(0, 11);
    check("tp_halt_count", 64'(bus.cycle_count_o), 64'd11);

    // Three single steps, dump_done in READY ignored.
    do_load(1'b0);
    for (int i = 0; i < 3; i++) step_case(1'b0);
    check("tp_step_count", 64'(bus.cycle_count_o), 64'd3);
    bus.dump_done_i = 1'b1;
    tick();
    bus.dump_done_i = 1'b0;
    check("ready_ignores_dump_done", 64'(bus.state_o), S_READY);
    run_case(0, 2);

    // Pure watchdog stop, then halt and watchdog on the same cycle.
    do_load(1'b0);
    run_case(5, 30);
    check("tp_wd_count", 64'(bus.cycle_count_o), 64'd5);
    do_load(1'b0);
    run_case(5, 5);

    reset_mid_run();

    // HALT already at WB when a step arrives.
    do_load(1'b0);
    step_case(1'b1);
    bus.halt_wb_i = 1'b0;
    send_cmd(CMD_RELOAD);
    check("halt_step_reload", 64'(bus.state_o), S_IDLE);

    for (int it = 0; it < 25; it++) begin
      do_load(1'($urandom_range(0, 1)));
      nsteps = $urandom_range(0, 3);
      for (int s = 0; s < nsteps; s++) begin
        step_case(1'b0);
        send_cmd(($urandom_range(0, 1) == 0) ? CMD_RELOAD : 8'h41);
        check("ready_ignores_junk", 64'(bus.state_o), S_READY);
      end
      case ($urandom_range(0, 3))
        0:       m = 0;
        1:       m = (c_model > 0) ? $urandom_range(1, c_model) : 0;
        default: m = c_model + $urandom_range(1, 20);
      endcase
      h = $urandom_range(1, 20);
      run_case(m, h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
